// File: rtl/dmux_4way_pkg.sv
// Shared channel-select constants for the 4-way demultiplexer.
package dmux_4way_pkg;

    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_t;

    localparam int unsigned NUM_CH = 4;

endpackage

// File: rtl/dmux_4way_core.sv
// Combinational 1-to-4 routing: the selected output follows in, all others are zero.
module dmux_4way_core
    import dmux_4way_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    always_comb begin
        a = '0;
        b = '0;
        c = '0;
        d = '0;
        unique case (sel_t'(sel))
            SEL_A: a = in;
            SEL_B: b = in;
            SEL_C: c = in;
            SEL_D: d = in;
        endcase
    end

endmodule

// File: rtl/dmux_4way.sv
// 4-way demux with registered copies of each output and, when DMUX_4WAY_STATS_EN
// is defined, saturating per-channel activity counters.
module dmux_4way
    import dmux_4way_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] d_q
`ifdef DMUX_4WAY_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
`endif
);

    dmux_4way_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .in (in),
        .sel(sel),
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            c_q <= c;
            d_q <= d;
        end
    end

`ifdef DMUX_4WAY_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_CH];

    // Only the selected channel can count, so at most one counter moves per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if ((in != '0) && (cnt[sel] != '1)) begin
            cnt[sel] <= cnt[sel] + CNT_W'(1);
        end
    end

    assign cnt_a = cnt[SEL_A];
    assign cnt_b = cnt[SEL_B];
    assign cnt_c = cnt[SEL_C];
    assign cnt_d = cnt[SEL_D];
`endif

endmodule

// File: tb/tb_dmux_4way.sv
// Self-checking bench for dmux_4way: a WIDTH=4 and a default WIDTH=1 instance
// checked against a channel-array reference model (counters when DMUX_4WAY_STATS_EN).
module tb_dmux_4way;

    logic       clk;
    logic       reset;
    logic [3:0] in;
    logic [1:0] sel;

    logic [3:0] w_a, w_b, w_c, w_d, w_aq, w_bq, w_cq, w_dq;
    logic       n_a, n_b, n_c, n_d, n_aq, n_bq, n_cq, n_dq;
    logic [3:0] comb_obs [2][4];
    logic [3:0] reg_obs  [2][4];

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned failed = 0;

    // Reference model state: expected registered outputs and counters per DUT/channel.
    logic [3:0] exp_q   [2][4];
    int         exp_cnt [2][4];

`ifdef DMUX_4WAY_STATS_EN
    logic [7:0] wc_a, wc_b, wc_c, wc_d, nc_a, nc_b, nc_c, nc_d;
    logic [7:0] cnt_obs [2][4];
    assign cnt_obs[0] = '{wc_a, wc_b, wc_c, wc_d};
    assign cnt_obs[1] = '{nc_a, nc_b, nc_c, nc_d};
`endif

    dmux_4way #(
        .WIDTH(4),
        .CNT_W(8)
    ) dut_w4 (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .sel  (sel),
        .a    (w_a),
        .b    (w_b),
        .c    (w_c),
        .d    (w_d),
        .a_q  (w_aq),
        .b_q  (w_bq),
        .c_q  (w_cq),
        .d_q  (w_dq)
`ifdef DMUX_4WAY_STATS_EN
        ,
        .cnt_a(wc_a),
        .cnt_b(wc_b),
        .cnt_c(wc_c),
        .cnt_d(wc_d)
`endif
    );

    dmux_4way dut_w1 (
        .clk  (clk),
        .reset(reset),
        .in   (in[0]),
        .sel  (sel),
        .a    (n_a),
        .b    (n_b),
        .c    (n_c),
        .d    (n_d),
        .a_q  (n_aq),
        .b_q  (n_bq),
        .c_q  (n_cq),
        .d_q  (n_dq)
`ifdef DMUX_4WAY_STATS_EN
        ,
        .cnt_a(nc_a),
        .cnt_b(nc_b),
        .cnt_c(nc_c),
        .cnt_d(nc_d)
`endif
    );

    assign comb_obs[0] = '{w_a, w_b, w_c, w_d};
    assign comb_obs[1] = '{{3'b0, n_a}, {3'b0, n_b}, {3'b0, n_c}, {3'b0, n_d}};
    assign reg_obs[0]  = '{w_aq, w_bq, w_cq, w_dq};
    assign reg_obs[1]  = '{{3'b0, n_aq}, {3'b0, n_bq}, {3'b0, n_cq}, {3'b0, n_dq}};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] data_for(input int dv);
        return (dv == 0) ? in : {3'b0, in[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        for (int dv = 0; dv < 2; dv++)
            for (int ch = 0; ch < 4; ch++)
                check($sformatf("comb dut%0d ch%0d sel=%0d in=%0h", dv, ch, sel, in),
                      32'(comb_obs[dv][ch]),
                      32'((int'(sel) == ch) ? data_for(dv) : 4'h0));
    endtask

    task automatic check_regs();
        for (int dv = 0; dv < 2; dv++)
            for (int ch = 0; ch < 4; ch++) begin
                check($sformatf("q dut%0d ch%0d", dv, ch), 32'(reg_obs[dv][ch]), 32'(exp_q[dv][ch]));
`ifdef DMUX_4WAY_STATS_EN
                check($sformatf("cnt dut%0d ch%0d", dv, ch), 32'(cnt_obs[dv][ch]), 32'(exp_cnt[dv][ch]));
`endif
            end
    endtask

    // Model update uses the inputs present at the edge, then compares just after it.
    task automatic step();
        logic [3:0] nq [2][4];
        int         nc [2][4];
        for (int dv = 0; dv < 2; dv++)
            for (int ch = 0; ch < 4; ch++) begin
                nq[dv][ch] = (!reset && int'(sel) == ch) ? data_for(dv) : 4'h0;
                nc[dv][ch] = exp_cnt[dv][ch];
                if (reset) nc[dv][ch] = 0;
                else if (int'(sel) == ch && data_for(dv) != 4'h0 && nc[dv][ch] < 255)
                    nc[dv][ch] = nc[dv][ch] + 1;
            end
        @(posedge clk);
        #1;
        exp_q   = nq;
        exp_cnt = nc;
        check_regs();
    endtask

    initial begin
        for (int dv = 0; dv < 2; dv++)
            for (int ch = 0; ch < 4; ch++) begin
                exp_q[dv][ch]   = 4'h0;
                exp_cnt[dv][ch] = 0;
            end
        reset = 1'b1;
        in    = 4'h0;
        sel   = 2'b00;
        step();
        step();

        // Zero input routes to nothing, then a lone 1 to each channel in turn.
        reset = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check_comb();
        end
        in = 4'h1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check_comb();
        end

        // One-cycle latency into c_q; registers still clear before the edge.
        sel = 2'b10;
        #1;
        check_regs();
        step();
        check("c_q after one edge", 32'(w_cq), 32'h1);

        // Reset wins over capture with data present, capture resumes right after.
        reset = 1'b1;
        sel   = 2'b01;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("b_q after reset release", 32'(n_bq), 32'h1);

        // Wide data lands intact on b only.
        in = 4'hA;
        #1;
        check_comb();

        // Random traffic with mid-cycle input changes and occasional reset.
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(15) == 0);
            in    = 4'($urandom_range(15));
            sel   = 2'($urandom_range(3));
            #1;
            check_comb();
            in  = 4'($urandom_range(15));
            sel = 2'($urandom_range(3));
            #1;
            check_comb();
            step();
        end

        // Hold channel d long enough to reach saturation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        in    = 4'h1;
        sel   = 2'b11;
        repeat (300) step();
`ifdef DMUX_4WAY_STATS_EN
        check("cnt_d saturated", 32'(wc_d), 32'd255);
        check("cnt_a idle", 32'(wc_a), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
